load_store_unit: RTL and testbench
==================================

# load_store_unit

Sits between the core's memory stage and the ROM/RAM address decoder. Converts core load/store requests (RISC-V funct3 encoding) into 32-bit word-aligned memory accesses: drives the decoder's `Addr`/`MemWrite`, performs read-modify-write for byte and halfword stores, and extracts and extends load data. Stalls the core for the one-cycle registered memory read latency, and flags misaligned or illegal requests without touching memory.

## Interface
- `RAM_LAT`, 1: memory read latency in cycles. Only the value 1 is supported.
- `clk`  in  1  system clock; all state updates on the rising edge.
- `reset_n`  in  1  synchronous, active-low reset.
- `MemRead`  in  1  core load request; held until `Stall` is low.
- `MemWriteIn`  in  1  core store request; held until `Stall` is low.
- `Funct3`  in  3  access type:
  - loads: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU.
  - stores: 000 SB, 001 SH, 010 SW.
- `AddrIn`  in  32  byte address from the ALU.
- `WriteData`  in  32  store data; the low byte or halfword is used for SB/SH.
- `MemDataIn`  in  32  word from the selected ROM/RAM; valid the cycle after `Addr` is presented.
- `Addr`  out  32  word-aligned address to the decoder and memories; bits [1:0] are always 0.
- `MemWrite`  out  1  write enable to the decoder.
- `MemDataOut`  out  32  write word to the RAM.
- `ReadData`  out  32  extended load result (registered).
- `Stall`  out  1  core must hold its request and not advance.
- `Fault`  out  1  misaligned or illegal request this cycle.

## Operation
- Byte lanes are little-endian: byte offset k = `AddrIn[1:0]` maps to bits [8k+7:8k]. Halfword offset 2 maps to bits [31:16].
- FSM states: IDLE, LD_WAIT, LD_DONE, RMW_RD, RMW_WR.
- IDLE:
  - `Addr` = {`AddrIn`[31:2], 2'b00}.
  - The request is latched into the aligned address, offset, `Funct3` and `WriteData` registers.
- Fault check (IDLE, combinational). `Fault`=1 and `Stall`=0 when any of the following hold:
  - `MemRead` and `MemWriteIn` are both high.
  - The load `Funct3` is in {011, 110, 111}.
  - The store `Funct3` is not in {000, 001, 010}.
  - A halfword access has `AddrIn[0]`=1.
  - A word access has `AddrIn[1:0]`≠0.
  - On a fault: no state change, `MemWrite`=0, `ReadData` unchanged.
- Load: IDLE -> LD_WAIT -> LD_DONE -> IDLE.
  - In LD_WAIT, `ReadData` <= lane select of `MemDataIn`, sign-extended for LB/LH and zero-extended for LBU/LHU/LW.
- SW (aligned): completes in IDLE.
  - `MemWrite`=1, `MemDataOut`=`WriteData`, `Stall`=0, stays in IDLE.
- SB/SH: IDLE -> RMW_RD -> RMW_WR -> IDLE.
  - IDLE: issues a read with `MemWrite`=0.
  - RMW_RD: registers the merged word, i.e. `MemDataIn` with the target lane(s) replaced by `WriteData`[7:0] or [15:0].
  - RMW_WR: `MemWrite`=1, `MemDataOut`=merged word.
- `Addr` in every non-IDLE state is the latched aligned address.
- `MemWrite` is 0 outside IDLE-SW and RMW_WR.
- Stores to ROM or unmapped addresses are issued normally. The decoder discards them; no fault is raised.
- While `reset_n`=0, `MemWrite`, `Stall` and `Fault` are forced to 0 combinationally.

## Timing
- Reset values:
  - state IDLE.
  - `ReadData`, `MemDataOut`, latched registers = 0.
  - `Stall`=0, `Fault`=0, `MemWrite`=0.
- Cycle 0 is the cycle a valid request is seen in IDLE.
- Load:
  - `Stall`=1 in cycles 0–1 and 0 in cycle 2 (LD_DONE).
  - `ReadData` is valid from cycle 2 until the next load completes.
- SW: write occurs in cycle 0 with `Stall`=0, so the next request can be taken in cycle 1.
- SB/SH:
  - Read in cycle 0, merge registered at the end of cycle 1, write in cycle 2.
  - `Stall`=1 in cycles 0–1 and 0 in cycle 2.
- Back-to-back requests: the core advances on the edge ending the `Stall`=0 cycle. The next request is evaluated in IDLE one cycle later, with no bubble.
- Request inputs are ignored outside IDLE, since the latched copy is used.
- Reset taken at any edge returns to IDLE:
  - A pending RMW write is abandoned and never issued.
  - An in-flight load leaves `ReadData`=0.
- `Fault` is a single-cycle indication for as long as the faulting request is held. The core is responsible for trapping.

## Test plan
- Reset: hold `reset_n`=0 for 2 cycles with `MemWriteIn`=1 -> `MemWrite`=0, `Stall`=0 and `ReadData`=0 throughout.
- LB sign-extension: `AddrIn`=0x2003, `Funct3`=000, memory word 0x80FF_1234 -> `Stall` 1,1,0 and `ReadData`=0xFFFF_FF80. Repeat as LBU -> 0x0000_0080.
- LH at offset 2: `AddrIn`=0x2006, word 0x8001_5678 -> `Addr`=0x2004 and `ReadData`=0xFFFF_8001.
- SB RMW:
  - Stimulus: word at 0x2008 = 0x1122_3344; SB of 0xAB to 0x2009.
  - Cycle 0: `MemWrite`=0.
  - Cycle 2: `MemWrite`=1 and `MemDataOut`=0x1122_AB44.
  - A follow-up LW returns 0x1122_AB44.
- SW then LW back-to-back:
  - SW of 0xDEAD_BEEF to 0x2FFC -> single-cycle write with no stall.
  - The following LW starts in the next cycle and returns 0xDEAD_BEEF.
- Faults:
  - LW at 0x2002, SH at 0x2001, load `Funct3`=011, and `MemRead`=`MemWriteIn`=1 -> `Fault`=1, `Stall`=0, `MemWrite`=0.
  - Reset asserted during RMW_RD -> no write is issued.

Source files
------------

// File: rtl/load_store_unit_if.sv
// Bus bundle between the core memory stage, the load/store unit and the ROM/RAM decoder.
// The master side is the core plus memory; the slave side is the load/store unit.
interface load_store_unit_if;
    logic        MemRead;
    logic        MemWriteIn;
    logic [2:0]  Funct3;
    logic [31:0] AddrIn;
    logic [31:0] WriteData;
    logic [31:0] MemDataIn;
    logic [31:0] Addr;
    logic        MemWrite;
    logic [31:0] MemDataOut;
    logic [31:0] ReadData;
    logic        Stall;
    logic        Fault;

    modport master (
        output MemRead, MemWriteIn, Funct3, AddrIn, WriteData, MemDataIn,
        input  Addr, MemWrite, MemDataOut, ReadData, Stall, Fault
    );

    modport slave (
        input  MemRead, MemWriteIn, Funct3, AddrIn, WriteData, MemDataIn,
        output Addr, MemWrite, MemDataOut, ReadData, Stall, Fault
    );
endinterface

// File: rtl/load_store_unit.sv
// Load/store unit: turns RISC-V byte/half/word loads and stores into aligned word accesses,
// with read-modify-write for sub-word stores and a one-cycle registered memory read latency.
module load_store_unit #(
    parameter int RAM_LAT = 1
) (
    input  logic               clk,
    input  logic               reset_n,
    load_store_unit_if.slave   bus
);

    if (RAM_LAT != 1) begin : g_ram_lat_check
        $error("load_store_unit supports RAM_LAT == 1 only");
    end

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        LD_WAIT = 3'd1,
        LD_DONE = 3'd2,
        RMW_RD  = 3'd3,
        RMW_WR  = 3'd4
    } state_t;

    state_t      state_r;
    logic [29:0] addr_r;
    logic [1:0]  off_r;
    logic [2:0]  funct3_r;
    logic [31:0] wdata_r;
    logic [31:0] merged_r;
    logic [31:0] read_data_r;

    logic        fault_s;
    logic        ld_go_s;
    logic        sw_go_s;
    logic        rmw_go_s;
    logic        misalign_s;
    logic        bad_ld_s;
    logic        bad_st_s;

    function automatic logic [31:0] load_extend(input logic [31:0] word,
                                                input logic [1:0]  off,
                                                input logic [2:0]  f3);
        logic [31:0] sh;
        sh = word >> {off, 3'b000};
        case (f3)
            3'b000:  return {{24{sh[7]}}, sh[7:0]};
            3'b001:  return {{16{sh[15]}}, sh[15:0]};
            3'b100:  return {24'h00_0000, sh[7:0]};
            3'b101:  return {16'h0000, sh[15:0]};
            default: return word;
        endcase
    endfunction

    function automatic logic [31:0] merge_lanes(input logic [31:0] word,
                                                input logic [1:0]  off,
                                                input logic [2:0]  f3,
                                                input logic [31:0] wd);
        logic [31:0] m;
        m = word;
        case (f3[1:0])
            2'b00:   m[{off, 3'b000} +: 8]     = wd[7:0];
            2'b01:   m[{off[1], 4'b0000} +: 16] = wd[15:0];
            default: m = wd;
        endcase
        return m;
    endfunction

    // Request legality and dispatch decode, only meaningful while IDLE
    always_comb begin
        misalign_s = ((bus.Funct3[1:0] == 2'b01) && bus.AddrIn[0]) ||
                     ((bus.Funct3[1:0] == 2'b10) && (bus.AddrIn[1:0] != 2'b00));
        bad_ld_s   = bus.MemRead && (bus.Funct3 inside {3'b011, 3'b110, 3'b111});
        bad_st_s   = bus.MemWriteIn && !(bus.Funct3 inside {3'b000, 3'b001, 3'b010});
        fault_s    = (bus.MemRead || bus.MemWriteIn) &&
                     ((bus.MemRead && bus.MemWriteIn) || bad_ld_s || bad_st_s || misalign_s);
        ld_go_s    = bus.MemRead && !fault_s;
        sw_go_s    = bus.MemWriteIn && !fault_s && (bus.Funct3 == 3'b010);
        rmw_go_s   = bus.MemWriteIn && !fault_s && (bus.Funct3 != 3'b010);
    end

    // Memory-side outputs; reset forces the control strobes low
    always_comb begin
        bus.Addr       = {addr_r, 2'b00};
        bus.MemWrite   = 1'b0;
        bus.MemDataOut = 32'h0000_0000;
        bus.Stall      = 1'b0;
        bus.Fault      = 1'b0;
        if (!reset_n) begin
            bus.MemWrite   = 1'b0;
            bus.MemDataOut = 32'h0000_0000;
            bus.Stall      = 1'b0;
            bus.Fault      = 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    bus.Addr       = {bus.AddrIn[31:2], 2'b00};
                    bus.Fault      = fault_s;
                    bus.Stall      = ld_go_s || rmw_go_s;
                    bus.MemWrite   = sw_go_s;
                    bus.MemDataOut = sw_go_s ? bus.WriteData : 32'h0000_0000;
                end
                LD_WAIT: bus.Stall = 1'b1;
                RMW_RD:  bus.Stall = 1'b1;
                RMW_WR: begin
                    bus.MemWrite   = 1'b1;
                    bus.MemDataOut = merged_r;
                end
                default: bus.Stall = 1'b0;
            endcase
        end
    end

    assign bus.ReadData = read_data_r;

    // Sequencer: latches the accepted request and walks the load / RMW paths
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_r     <= IDLE;
            addr_r      <= 30'h0000_0000;
            off_r       <= 2'b00;
            funct3_r    <= 3'b000;
            wdata_r     <= 32'h0000_0000;
            merged_r    <= 32'h0000_0000;
            read_data_r <= 32'h0000_0000;
        end else begin
            case (state_r)
                IDLE: begin
                    if (ld_go_s || rmw_go_s || sw_go_s) begin
                        addr_r   <= bus.AddrIn[31:2];
                        off_r    <= bus.AddrIn[1:0];
                        funct3_r <= bus.Funct3;
                        wdata_r  <= bus.WriteData;
                    end
                    if (ld_go_s) begin
                        state_r <= LD_WAIT;
                    end else if (rmw_go_s) begin
                        state_r <= RMW_RD;
                    end else begin
                        state_r <= IDLE;
                    end
                end
                LD_WAIT: begin
                    read_data_r <= load_extend(bus.MemDataIn, off_r, funct3_r);
                    state_r     <= LD_DONE;
                end
                LD_DONE: state_r <= IDLE;
                RMW_RD: begin
                    merged_r <= merge_lanes(bus.MemDataIn, off_r, funct3_r, wdata_r);
                    state_r  <= RMW_WR;
                end
                RMW_WR:  state_r <= IDLE;
                default: state_r <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_load_store_unit.sv
// Self-checking bench for load_store_unit: directed vector table, reset corner cases,
// then randomized requests checked against a byte-level memory model.
module tb_load_store_unit;

    logic clk;
    logic reset_n;
    int   total;
    int   passed;
    logic [31:0] prev_rd;

    load_store_unit_if bus();

    load_store_unit #(.RAM_LAT(1)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Registered-read RAM seen by the unit
    logic [31:0] ram [0:1023];
    always @(posedge clk) begin
        if (bus.MemWrite) ram[bus.Addr[11:2]] <= bus.MemDataOut;
        bus.MemDataIn <= ram[bus.Addr[11:2]];
    end

    // Reference byte memory for the 0x2000-0x2FFF window
    logic [7:0] ref_b [0:4095];

    typedef struct {
        logic        ld;
        logic        st;
        logic [2:0]  f3;
        logic [31:0] addr;
        logic [31:0] wd;
        logic        fault;
        logic [31:0] val;
    } vec_t;

    vec_t vecs [24];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) $display("FAIL %s: got %h expected %h", name, act, exp);
        else passed++;
    endtask

    function automatic logic model_fault(input logic ld, input logic st,
                                         input logic [2:0] f3, input logic [31:0] a);
        int nbytes;
        if (ld && st) return 1'b1;
        if (ld && !(f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5})) return 1'b1;
        if (st && !(f3 inside {3'd0, 3'd1, 3'd2})) return 1'b1;
        nbytes = 1 << f3[1:0];
        return (a % nbytes) != 0;
    endfunction

    function automatic logic [31:0] model_load(input logic [2:0] f3, input logic [31:0] a);
        int unsigned v;
        case (f3[1:0])
            2'd0:    v = ref_b[a[11:0]];
            2'd1:    v = ref_b[a[11:0]] + 256 * ref_b[a[11:0] + 12'd1];
            default: v = ref_b[a[11:0]] + 256 * ref_b[a[11:0] + 12'd1]
                         + 65536 * ref_b[a[11:0] + 12'd2] + 16777216 * ref_b[a[11:0] + 12'd3];
        endcase
        if (f3 == 3'd0 && v >= 128) v = v - 256;
        if (f3 == 3'd1 && v >= 32768) v = v - 65536;
        return 32'(v);
    endfunction

    function automatic logic [31:0] model_store_word(input logic [2:0] f3, input logic [31:0] a,
                                                     input logic [31:0] wd);
        logic [7:0] w [4];
        logic [11:0] base;
        int off;
        int n;
        base = {a[11:2], 2'b00};
        off  = a % 4;
        n    = 1 << f3[1:0];
        for (int i = 0; i < 4; i++) w[i] = ref_b[base + 12'(i)];
        for (int i = 0; i < n; i++) w[off + i] = 8'(wd >> (8 * i));
        return {w[3], w[2], w[1], w[0]};
    endfunction

    task automatic model_commit(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] wd);
        int n;
        n = 1 << f3[1:0];
        for (int i = 0; i < n; i++) ref_b[a[11:0] + 12'(i)] = 8'(wd >> (8 * i));
    endtask

    task automatic idle_inputs();
        bus.MemRead    = 1'b0;
        bus.MemWriteIn = 1'b0;
    endtask

    // One request, called just after a rising edge; returns just after the edge that retires it
    task automatic do_req(input logic ld, input logic st, input logic [2:0] f3,
                          input logic [31:0] a, input logic [31:0] wd,
                          input logic exp_f, input logic [31:0] exp_v);
        logic [31:0] aa;
        aa = {a[31:2], 2'b00};
        bus.MemRead    = ld;
        bus.MemWriteIn = st;
        bus.Funct3     = f3;
        bus.AddrIn     = a;
        bus.WriteData  = wd;
        @(negedge clk);
        chk("addr_c0", bus.Addr, aa);
        chk("fault_c0", 32'(bus.Fault), 32'(exp_f));
        if (exp_f) begin
            chk("fault_stall", 32'(bus.Stall), 32'd0);
            chk("fault_memwrite", 32'(bus.MemWrite), 32'd0);
            @(posedge clk); #1;
            chk("fault_readdata", bus.ReadData, prev_rd);
            idle_inputs();
        end else if (st && f3 == 3'b010) begin
            chk("sw_stall", 32'(bus.Stall), 32'd0);
            chk("sw_memwrite", 32'(bus.MemWrite), 32'd1);
            chk("sw_dataout", bus.MemDataOut, wd);
            @(posedge clk); #1;
            idle_inputs();
            model_commit(f3, a, wd);
        end else begin
            chk("c0_stall", 32'(bus.Stall), 32'd1);
            chk("c0_memwrite", 32'(bus.MemWrite), 32'd0);
            @(posedge clk); #1;
            bus.AddrIn    = $urandom;
            bus.WriteData = $urandom;
            bus.Funct3    = 3'($urandom_range(0, 7));
            @(negedge clk);
            chk("c1_stall", 32'(bus.Stall), 32'd1);
            chk("c1_memwrite", 32'(bus.MemWrite), 32'd0);
            chk("c1_addr", bus.Addr, aa);
            @(posedge clk); #1;
            @(negedge clk);
            chk("c2_stall", 32'(bus.Stall), 32'd0);
            chk("c2_addr", bus.Addr, aa);
            if (ld) begin
                chk("load_readdata", bus.ReadData, exp_v);
                chk("load_memwrite", 32'(bus.MemWrite), 32'd0);
                prev_rd = exp_v;
            end else begin
                chk("rmw_memwrite", 32'(bus.MemWrite), 32'd1);
                chk("rmw_dataout", bus.MemDataOut, exp_v);
            end
            @(posedge clk); #1;
            idle_inputs();
            if (st) model_commit(f3, a, wd);
        end
    endtask

    initial begin
        total   = 0;
        passed  = 0;
        prev_rd = 32'h0000_0000;

        vecs[0]  = '{1'b0, 1'b1, 3'b010, 32'h0000_2000, 32'h80FF_1234, 1'b0, 32'h0000_0000};
        vecs[1]  = '{1'b1, 1'b0, 3'b000, 32'h0000_2003, 32'h0000_0000, 1'b0, 32'hFFFF_FF80};
        vecs[2]  = '{1'b1, 1'b0, 3'b100, 32'h0000_2003, 32'h0000_0000, 1'b0, 32'h0000_0080};
        vecs[3]  = '{1'b0, 1'b1, 3'b010, 32'h0000_2004, 32'h8001_5678, 1'b0, 32'h0000_0000};
        vecs[4]  = '{1'b1, 1'b0, 3'b001, 32'h0000_2006, 32'h0000_0000, 1'b0, 32'hFFFF_8001};
        vecs[5]  = '{1'b0, 1'b1, 3'b010, 32'h0000_2008, 32'h1122_3344, 1'b0, 32'h0000_0000};
        vecs[6]  = '{1'b0, 1'b1, 3'b000, 32'h0000_2009, 32'h5555_55AB, 1'b0, 32'h1122_AB44};
        vecs[7]  = '{1'b1, 1'b0, 3'b010, 32'h0000_2008, 32'h0000_0000, 1'b0, 32'h1122_AB44};
        vecs[8]  = '{1'b0, 1'b1, 3'b001, 32'h0000_200A, 32'h1234_CAFE, 1'b0, 32'hCAFE_AB44};
        vecs[9]  = '{1'b1, 1'b0, 3'b101, 32'h0000_200A, 32'h0000_0000, 1'b0, 32'h0000_CAFE};
        vecs[10] = '{1'b1, 1'b0, 3'b001, 32'h0000_2008, 32'h0000_0000, 1'b0, 32'hFFFF_AB44};
        vecs[11] = '{1'b1, 1'b0, 3'b000, 32'h0000_2000, 32'h0000_0000, 1'b0, 32'h0000_0034};
        vecs[12] = '{1'b1, 1'b0, 3'b101, 32'h0000_2004, 32'h0000_0000, 1'b0, 32'h0000_5678};
        vecs[13] = '{1'b0, 1'b1, 3'b010, 32'h0000_2FFC, 32'hDEAD_BEEF, 1'b0, 32'h0000_0000};
        vecs[14] = '{1'b1, 1'b0, 3'b010, 32'h0000_2FFC, 32'h0000_0000, 1'b0, 32'hDEAD_BEEF};
        vecs[15] = '{1'b1, 1'b0, 3'b010, 32'h0000_2002, 32'h0000_0000, 1'b1, 32'h0000_0000};
        vecs[16] = '{1'b0, 1'b1, 3'b001, 32'h0000_2001, 32'h0000_9999, 1'b1, 32'h0000_0000};
        vecs[17] = '{1'b1, 1'b0, 3'b011, 32'h0000_2000, 32'h0000_0000, 1'b1, 32'h0000_0000};
        vecs[18] = '{1'b1, 1'b1, 3'b010, 32'h0000_2000, 32'h0BAD_0BAD, 1'b1, 32'h0000_0000};
        vecs[19] = '{1'b0, 1'b1, 3'b100, 32'h0000_2000, 32'h0000_00EE, 1'b1, 32'h0000_0000};
        vecs[20] = '{1'b1, 1'b0, 3'b000, 32'h0000_2001, 32'h0000_0000, 1'b0, 32'h0000_0012};
        vecs[21] = '{1'b0, 1'b1, 3'b000, 32'h0000_2FFF, 32'h0000_0077, 1'b0, 32'h77AD_BEEF};
        vecs[22] = '{1'b1, 1'b0, 3'b010, 32'h0000_2FFC, 32'h0000_0000, 1'b0, 32'h77AD_BEEF};
        vecs[23] = '{1'b1, 1'b0, 3'b111, 32'h0000_2004, 32'h0000_0000, 1'b1, 32'h0000_0000};

        // Reset held with a store request pending
        reset_n        = 1'b0;
        bus.MemRead    = 1'b0;
        bus.MemWriteIn = 1'b1;
        bus.Funct3     = 3'b010;
        bus.AddrIn     = 32'h0000_2000;
        bus.WriteData  = 32'h1234_5678;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            chk("rst_memwrite", 32'(bus.MemWrite), 32'd0);
            chk("rst_stall", 32'(bus.Stall), 32'd0);
            chk("rst_fault", 32'(bus.Fault), 32'd0);
            chk("rst_readdata", bus.ReadData, 32'h0000_0000);
        end
        @(posedge clk); #1;
        reset_n = 1'b1;
        idle_inputs();

        for (int i = 0; i < 24; i++)
            do_req(vecs[i].ld, vecs[i].st, vecs[i].f3, vecs[i].addr, vecs[i].wd,
                   vecs[i].fault, vecs[i].val);

        // Reset during RMW_RD: the write must never be issued
        bus.MemRead    = 1'b0;
        bus.MemWriteIn = 1'b1;
        bus.Funct3     = 3'b000;
        bus.AddrIn     = 32'h0000_2008;
        bus.WriteData  = 32'h0000_00EE;
        @(negedge clk);
        chk("rmwrst_c0_stall", 32'(bus.Stall), 32'd1);
        @(posedge clk); #1;
        reset_n = 1'b0;
        @(negedge clk);
        chk("rmwrst_memwrite", 32'(bus.MemWrite), 32'd0);
        chk("rmwrst_stall", 32'(bus.Stall), 32'd0);
        @(posedge clk); #1;
        reset_n = 1'b1;
        idle_inputs();
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            chk("rmwrst_after_memwrite", 32'(bus.MemWrite), 32'd0);
            chk("rmwrst_after_stall", 32'(bus.Stall), 32'd0);
            @(posedge clk); #1;
        end
        prev_rd = 32'h0000_0000;
        do_req(1'b1, 1'b0, 3'b010, 32'h0000_2008, 32'h0, 1'b0, 32'hCAFE_AB44);

        // Reset during LD_WAIT leaves ReadData cleared
        bus.MemRead    = 1'b1;
        bus.MemWriteIn = 1'b0;
        bus.Funct3     = 3'b010;
        bus.AddrIn     = 32'h0000_2FFC;
        @(posedge clk); #1;
        reset_n = 1'b0;
        @(posedge clk); #1;
        reset_n = 1'b1;
        idle_inputs();
        @(negedge clk);
        chk("ldrst_readdata", bus.ReadData, 32'h0000_0000);
        chk("ldrst_stall", 32'(bus.Stall), 32'd0);
        prev_rd = 32'h0000_0000;
        @(posedge clk); #1;

        // Randomized traffic in a 64-byte window against the byte model
        for (int i = 0; i < 16; i++)
            do_req(1'b0, 1'b1, 3'b010, 32'h0000_2100 + 32'(4 * i), $urandom, 1'b0, 32'h0);
        for (int i = 0; i < 250; i++) begin
            logic        ld;
            logic        st;
            logic [2:0]  f3;
            logic [31:0] a;
            logic [31:0] wd;
            logic        ef;
            logic [31:0] ev;
            int r;
            r  = $urandom_range(0, 9);
            ld = (r < 5) || (r == 9);
            st = (r >= 5);
            if ($urandom_range(0, 3) != 0) f3 = ld ? 3'($urandom_range(0, 2)) : 3'($urandom_range(0, 2));
            else f3 = 3'($urandom_range(0, 7));
            if (ld && !st && $urandom_range(0, 1) == 1 && f3 != 3'b010) f3[2] = 1'b1;
            a  = 32'h0000_2100 + 32'($urandom_range(0, 63));
            wd = $urandom;
            ef = model_fault(ld, st, f3, a);
            ev = ld ? model_load(f3, a) : model_store_word(f3, a, wd);
            do_req(ld, st, f3, a, wd, ef, ev);
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
